// File: rtl/pq_scheduler.sv
// pq_scheduler: arbitrates push/pop requests from NREQ requesters onto a single
// priority queue (pqueue) and can drain that queue on demand.
//
// Each accepted request takes three cycles:
//   IDLE  (T)   round-robin grant, req_ready[winner] combinational,
//               rejection decided from pq_full / pq_empty
//   ISSUE (T+1) registered pq_cmd / pq_in drive the pqueue, pop captures head
//   RESP  (T+2) one-cycle rsp_valid[winner] with rsp_err / rsp_data
// FLUSH pops every cycle until pq_empty is seen, then pulses flush_done.
//
// Ports
//   clock, reset_n           rising-edge clock, synchronous active-low reset
//   req_valid/req_op/req_data per-requester request (op 0 = PUSH, 1 = POP)
//   req_ready                one-hot grant (combinational, IDLE only)
//   rsp_valid/rsp_data/rsp_err one-cycle response for the granted requester
//   flush, flush_done        drain request (honoured in IDLE) and completion pulse
//   pq_cmd, pq_in            registered pqueue command (NOOP/PUSH/POP) and data
//   pq_out, pq_full, pq_empty pqueue head value and status
module pq_scheduler #(
   parameter int N    = 6,
   parameter int W    = $clog2(N),
   parameter int NREQ = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_op,
   input  logic [NREQ*W-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   input  logic              flush,
   output logic              flush_done,
   output logic [1:0]        pq_cmd,
   output logic [W-1:0]      pq_in,
   input  logic [W-1:0]      pq_out,
   input  logic              pq_full,
   input  logic              pq_empty
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] CMD_NOOP = 2'd0;
   localparam logic [1:0] CMD_PUSH = 2'd1;
   localparam logic [1:0] CMD_POP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   // registered state
   state_t          state_r;
   logic [IW-1:0]   ptr_r;
   logic [IW-1:0]   win_r;
   logic            op_r;
   logic            err_r;
   logic [1:0]      pq_cmd_r;
   logic [W-1:0]    pq_in_r;
   logic [NREQ-1:0] rsp_valid_r;
   logic [W-1:0]    rsp_data_r;
   logic            rsp_err_r;

   // next-state values
   state_t          state_nx_s;
   logic [IW-1:0]   ptr_nx_s;
   logic [IW-1:0]   win_nx_s;
   logic            op_nx_s;
   logic            err_nx_s;
   logic [1:0]      pq_cmd_nx_s;
   logic [W-1:0]    pq_in_nx_s;
   logic [NREQ-1:0] rsp_valid_nx_s;
   logic [W-1:0]    rsp_data_nx_s;
   logic            rsp_err_nx_s;

   // arbiter results
   logic            found_s;
   logic [IW-1:0]   winner_s;
   logic [IW-1:0]   idx_s;
   logic [IW:0]     sum_s;
   logic [W-1:0]    win_data_s;
   logic            reject_s;
   logic [NREQ-1:0] req_ready_s;
   logic            flush_done_s;

   // Round-robin search: first valid requester at or after ptr_r, wrapping
   always_comb begin
      found_s    = 1'b0;
      winner_s   = '0;
      idx_s      = '0;
      sum_s      = '0;
      win_data_s = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum_s = {1'b0, ptr_r} + (IW+1)'(k);
         if (sum_s >= (IW+1)'(NREQ)) begin
            sum_s = sum_s - (IW+1)'(NREQ);
         end else begin
            sum_s = sum_s;
         end
         idx_s = sum_s[IW-1:0];
         if (!found_s && req_valid[idx_s]) begin
            found_s  = 1'b1;
            winner_s = idx_s;
         end else begin
            found_s  = found_s;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (winner_s == IW'(i)) begin
            win_data_s = req_data[i*W +: W];
         end else begin
            win_data_s = win_data_s;
         end
      end
   end

   // Next-state and output decode; pqueue command defaults to NOOP/0 so that
   // only the grant and flush paths can ever schedule a PUSH or POP
   always_comb begin
      state_nx_s     = state_r;
      ptr_nx_s       = ptr_r;
      win_nx_s       = win_r;
      op_nx_s        = op_r;
      err_nx_s       = err_r;
      pq_cmd_nx_s    = CMD_NOOP;
      pq_in_nx_s     = '0;
      rsp_valid_nx_s = '0;
      rsp_data_nx_s  = '0;
      rsp_err_nx_s   = 1'b0;
      req_ready_s    = '0;
      flush_done_s   = 1'b0;
      reject_s       = 1'b0;

      case (state_r)
         IDLE: begin
            if (flush) begin
               // flush wins over requests; the first POP is issued blindly,
               // an extra pop on an empty queue is harmless
               state_nx_s  = FLUSH;
               pq_cmd_nx_s = CMD_POP;
            end else if (found_s) begin
               req_ready_s[winner_s] = 1'b1;
               win_nx_s = winner_s;
               op_nx_s  = req_op[winner_s];
               if (winner_s == IW'(NREQ-1)) begin
                  ptr_nx_s = '0;
               end else begin
                  ptr_nx_s = winner_s + IW'(1);
               end
               reject_s = req_op[winner_s] ? pq_empty : pq_full;
               err_nx_s = reject_s;
               if (reject_s) begin
                  pq_cmd_nx_s = CMD_NOOP;
               end else if (req_op[winner_s]) begin
                  pq_cmd_nx_s = CMD_POP;
               end else begin
                  pq_cmd_nx_s = CMD_PUSH;
                  pq_in_nx_s  = win_data_s;
               end
               state_nx_s = ISSUE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ISSUE: begin
            // pq_out still shows the head before this cycle's pop lands
            rsp_valid_nx_s[win_r] = 1'b1;
            rsp_err_nx_s = err_r;
            if (op_r && !err_r) begin
               rsp_data_nx_s = pq_out;
            end else begin
               rsp_data_nx_s = '0;
            end
            state_nx_s = RESP;
         end
         RESP: begin
            state_nx_s = IDLE;
         end
         FLUSH: begin
            if (pq_empty) begin
               flush_done_s = 1'b1;
               state_nx_s   = IDLE;
            end else begin
               pq_cmd_nx_s  = CMD_POP;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         ptr_r       <= '0;
         win_r       <= '0;
         op_r        <= 1'b0;
         err_r       <= 1'b0;
         pq_cmd_r    <= CMD_NOOP;
         pq_in_r     <= '0;
         rsp_valid_r <= '0;
         rsp_data_r  <= '0;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         ptr_r       <= ptr_nx_s;
         win_r       <= win_nx_s;
         op_r        <= op_nx_s;
         err_r       <= err_nx_s;
         pq_cmd_r    <= pq_cmd_nx_s;
         pq_in_r     <= pq_in_nx_s;
         rsp_valid_r <= rsp_valid_nx_s;
         rsp_data_r  <= rsp_data_nx_s;
         rsp_err_r   <= rsp_err_nx_s;
      end
   end

   // grant and flush_done are combinational, so hold them low while in reset
   assign req_ready  = req_ready_s & {NREQ{reset_n}};
   assign flush_done = flush_done_s & reset_n;
   assign rsp_valid  = rsp_valid_r;
   assign rsp_data   = rsp_data_r;
   assign rsp_err    = rsp_err_r;
   assign pq_cmd     = pq_cmd_r;
   assign pq_in      = pq_in_r;

endmodule

// File: tb/tb_pq_scheduler.sv
// Directed testbench for pq_scheduler with a behavioural min-first pqueue.
module tb_pq_scheduler;

   localparam int N    = 6;
   localparam int W    = 3;
   localparam int NREQ = 3;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_op;
   logic [NREQ*W-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              rsp_err;
   logic              flush;
   logic              flush_done;
   logic [1:0]        pq_cmd;
   logic [W-1:0]      pq_in;
   logic [W-1:0]      pq_out;
   logic              pq_full;
   logic              pq_empty;

   int checks = 0;
   int errors = 0;

   pq_scheduler #(.N(N), .W(W), .NREQ(NREQ)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .flush(flush), .flush_done(flush_done),
      .pq_cmd(pq_cmd), .pq_in(pq_in), .pq_out(pq_out),
      .pq_full(pq_full), .pq_empty(pq_empty)
   );

   always #5 clock = ~clock;

   // behavioural pqueue: sorted ascending, head = smallest value
   logic [W-1:0] pqm    [N];
   logic [W-1:0] pq_tmp [N];
   int pq_cnt = 0;
   int pq_tcnt;
   int pq_pos;

   always_comb begin
      pq_tcnt = pq_cnt;
      pq_pos  = pq_cnt;
      for (int i = 0; i < N; i++) pq_tmp[i] = pqm[i];
      if (pq_cmd == 2'd1 && pq_cnt < N) begin
         for (int i = N-1; i >= 0; i--)
            if (i < pq_cnt && pq_in < pqm[i]) pq_pos = i;
         for (int i = 1; i < N; i++)
            if (i > pq_pos && i <= pq_cnt) pq_tmp[i] = pqm[i-1];
         pq_tmp[pq_pos] = pq_in;
         pq_tcnt = pq_cnt + 1;
      end else if (pq_cmd == 2'd2 && pq_cnt > 0) begin
         for (int i = 0; i < N-1; i++) pq_tmp[i] = pqm[i+1];
         pq_tcnt = pq_cnt - 1;
      end
   end

   always @(posedge clock) begin
      for (int i = 0; i < N; i++) pqm[i] <= pq_tmp[i];
      pq_cnt <= pq_tcnt;
   end

   assign pq_out   = (pq_cnt > 0) ? pqm[0] : 3'd0;
   assign pq_full  = (pq_cnt == N);
   assign pq_empty = (pq_cnt == 0);

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; req_valid = 3'b111; req_op = 3'b000; req_data = 9'd0; flush = 1'b0;
      tick; tick;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
      checks++; if (pq_cmd !== 2'd0) begin errors++; $display("FAIL reset_cmd got %0d exp 0", pq_cmd); end
      checks++; if (pq_in !== 3'd0) begin errors++; $display("FAIL reset_in got %0d exp 0", pq_in); end
      checks++; if (rsp_valid !== 3'b000 || rsp_err !== 1'b0 || rsp_data !== 3'd0) begin
         errors++; $display("FAIL reset_rsp got v=%b e=%b d=%0d exp 000/0/0", rsp_valid, rsp_err, rsp_data); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b exp 0", flush_done); end
      req_valid = 3'b000; reset_n = 1'b1;
      tick;
   endtask

   task automatic test_single_push;
      req_valid = 3'b001; req_op = 3'b000; req_data = {3'd0, 3'd0, 3'd5};
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL push_ready got %b exp 001", req_ready); end
      tick; req_valid = 3'b000;
      checks++; if (pq_cmd !== 2'd1 || pq_in !== 3'd5) begin errors++; $display("FAIL push_issue got cmd=%0d in=%0d exp 1/5", pq_cmd, pq_in); end
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL push_ready_issue got %b exp 000", req_ready); end
      tick;
      checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_data !== 3'd0) begin
         errors++; $display("FAIL push_rsp got v=%b e=%b d=%0d exp 001/0/0", rsp_valid, rsp_err, rsp_data); end
      checks++; if (pq_cmd !== 2'd0) begin errors++; $display("FAIL push_resp_cmd got %0d exp 0", pq_cmd); end
      tick;
      checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL push_rsp_pulse got %b exp 000", rsp_valid); end
   endtask

   task automatic test_fairness;
      logic [2:0] exp_rdy;
      logic [2:0] exp_in;
      reset_n = 1'b0; tick; reset_n = 1'b1;
      req_valid = 3'b111; req_op = 3'b000; req_data = {3'd3, 3'd2, 3'd1};
      #1;
      for (int g = 0; g < 4; g++) begin
         exp_rdy = 3'b001 << (g % 3);
         exp_in  = 3'(g % 3 + 1);
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", g, req_ready, exp_rdy); end
         tick;
         if (g == 3) req_valid = 3'b000;
         checks++; if (pq_cmd !== 2'd1 || pq_in !== exp_in) begin errors++; $display("FAIL fair_issue%0d got cmd=%0d in=%0d exp 1/%0d", g, pq_cmd, pq_in, exp_in); end
         tick;
         checks++; if (rsp_valid !== exp_rdy || rsp_err !== 1'b0) begin errors++; $display("FAIL fair_rsp%0d got v=%b e=%b exp %b/0", g, rsp_valid, rsp_err, exp_rdy); end
         checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL fair_ready_resp%0d got %b exp 000", g, req_ready); end
         tick;
      end
   endtask

   task automatic test_flush;
      int pops;
      bit done;
      pops = 0; done = 1'b0;
      flush = 1'b1; req_valid = 3'b001; req_op = 3'b000;
      #1;
      checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL flush_prec_ready got %b exp 000", req_ready); end
      tick; flush = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         if (flush_done === 1'b1) begin
            done = 1'b1;
         end else begin
            checks++; if (pq_cmd !== 2'd2 || req_ready !== 3'b000) begin
               errors++; $display("FAIL flush_pop got cmd=%0d ready=%b exp 2/000", pq_cmd, req_ready); end
            pops++;
            tick;
         end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_timeout got done=%b exp 1", done); end
      checks++; if (pops < 3) begin errors++; $display("FAIL flush_pop_count got %0d exp >=3", pops); end
      checks++; if (pq_empty !== 1'b1 || req_ready !== 3'b000) begin
         errors++; $display("FAIL flush_done_state got empty=%b ready=%b exp 1/000", pq_empty, req_ready); end
      req_valid = 3'b000;
      tick;
      checks++; if (pq_cmd !== 2'd0 || flush_done !== 1'b0) begin
         errors++; $display("FAIL flush_exit got cmd=%0d done=%b exp 0/0", pq_cmd, flush_done); end
   endtask

   task automatic test_pop_empty;
      req_valid = 3'b010; req_op = 3'b010; req_data = {3'd0, 3'd6, 3'd0};
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL popempty_ready got %b exp 010", req_ready); end
      tick; req_valid = 3'b000;
      checks++; if (pq_cmd !== 2'd0) begin errors++; $display("FAIL popempty_cmd got %0d exp 0", pq_cmd); end
      tick;
      checks++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b1 || rsp_data !== 3'd0) begin
         errors++; $display("FAIL popempty_rsp got v=%b e=%b d=%0d exp 010/1/0", rsp_valid, rsp_err, rsp_data); end
      tick;
   endtask

   task automatic test_ordering;
      logic       op   [7];
      logic [2:0] din  [7];
      logic [1:0] ecmd [7];
      logic [2:0] ein  [7];
      logic [2:0] edat [7];
      logic       eerr [7];
      op   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      din  = '{3'd4, 3'd1, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7};
      ecmd = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
      ein  = '{3'd4, 3'd1, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
      edat = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
      eerr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int s = 0; s < 7; s++) begin
         req_valid = 3'b100; req_op = {op[s], 2'b00}; req_data = {din[s], 3'd0, 3'd0};
         #1;
         checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL order_ready%0d got %b exp 100", s, req_ready); end
         tick; req_valid = 3'b000;
         checks++; if (pq_cmd !== ecmd[s] || pq_in !== ein[s]) begin
            errors++; $display("FAIL order_issue%0d got cmd=%0d in=%0d exp %0d/%0d", s, pq_cmd, pq_in, ecmd[s], ein[s]); end
         tick;
         checks++; if (rsp_valid !== 3'b100 || rsp_err !== eerr[s] || rsp_data !== edat[s]) begin
            errors++; $display("FAIL order_rsp%0d got v=%b e=%b d=%0d exp 100/%b/%0d", s, rsp_valid, rsp_err, rsp_data, eerr[s], edat[s]); end
         tick;
      end
   endtask

   task automatic test_full;
      logic [2:0] din [7];
      din = '{3'd6, 3'd2, 3'd7, 3'd0, 3'd5, 3'd1, 3'd3};
      for (int s = 0; s < 7; s++) begin
         req_valid = 3'b001; req_op = 3'b000; req_data = {3'd0, 3'd0, din[s]};
         #1;
         tick; req_valid = 3'b000;
         checks++; if (pq_cmd !== ((s < 6) ? 2'd1 : 2'd0)) begin
            errors++; $display("FAIL full_cmd%0d got %0d exp %0d", s, pq_cmd, (s < 6) ? 1 : 0); end
         tick;
         checks++; if (rsp_valid !== 3'b001 || rsp_err !== ((s < 6) ? 1'b0 : 1'b1)) begin
            errors++; $display("FAIL full_rsp%0d got v=%b e=%b exp 001/%0d", s, rsp_valid, rsp_err, (s < 6) ? 0 : 1); end
         tick;
      end
   endtask

   task automatic test_reset_in_issue;
      req_valid = 3'b111; req_op = 3'b111; req_data = 9'd0;
      #1;
      checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL rst_issue_ready got %b exp 010", req_ready); end
      tick;
      checks++; if (pq_cmd !== 2'd2) begin errors++; $display("FAIL rst_issue_cmd got %0d exp 2", pq_cmd); end
      reset_n = 1'b0; req_valid = 3'b000;
      tick;
      checks++; if (pq_cmd !== 2'd0 || rsp_valid !== 3'b000 || req_ready !== 3'b000) begin
         errors++; $display("FAIL rst_abort got cmd=%0d v=%b ready=%b exp 0/000/000", pq_cmd, rsp_valid, req_ready); end
      reset_n = 1'b1;
      tick;
      checks++; if (rsp_valid !== 3'b000 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL rst_no_rsp got v=%b e=%b exp 000/0", rsp_valid, rsp_err); end
      req_valid = 3'b111; req_op = 3'b111;
      #1;
      checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL rst_ptr_ready got %b exp 001", req_ready); end
      tick; req_valid = 3'b000;
      checks++; if (pq_cmd !== 2'd2) begin errors++; $display("FAIL rst_pop_cmd got %0d exp 2", pq_cmd); end
      tick;
      checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_data !== 3'd1) begin
         errors++; $display("FAIL rst_pop_rsp got v=%b e=%b d=%0d exp 001/0/1", rsp_valid, rsp_err, rsp_data); end
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      test_single_push;
      test_fairness;
      test_flush;
      test_pop_empty;
      test_ordering;
      test_full;
      test_reset_in_issue;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
